// File: rtl/sequence_entry_pkg.sv
// Shared sequence geometry and entry FSM states for the game datapath.
// The controller and the sequence generator import the same defaults.
package sequence_entry_pkg;

    localparam int unsigned SEQ_LEN_DEFAULT         = 4;
    localparam int unsigned SYM_W_DEFAULT           = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StReport
    } entry_state_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stability-counter debounce and a rising-edge press pulse.
// The same block serves both the player entry button and the controller's enter button.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/sequence_entry.sv
// Captures the player's attempt at the target sequence, one symbol per debounced press,
// and reports completion (entry_done pulse) and a held match verdict (seq_match).
module sequence_entry
    import sequence_entry_pkg::*;
#(
    parameter int unsigned  SEQ_LEN         = SEQ_LEN_DEFAULT,
    parameter int unsigned  SYM_W           = SYM_W_DEFAULT,
    parameter int unsigned  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    localparam int unsigned CNT_W           = $clog2(SEQ_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn,
    input  logic [SYM_W-1:0]         sw,
    input  logic                     seq_ld,
    input  logic [SEQ_LEN*SYM_W-1:0] target,
    output logic                     entry_done,
    output logic                     seq_match,
    output logic [CNT_W-1:0]         entry_count,
    output logic                     busy
);

    entry_state_e             state_q, state_d;
    logic [SEQ_LEN*SYM_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]         count_q, count_d, count_inc;
    logic                     mismatch_q, mismatch_d;
    logic                     match_q, match_d;
    logic                     miss;
    logic [SYM_W-1:0]         cur_sym;
    logic                     press;
    logic                     btn_level_unused;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn),
        .level  (btn_level_unused),
        .press  (press)
    );

    assign cur_sym   = target_q[count_q*SYM_W +: SYM_W];
    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        match_d    = match_q;
        miss       = mismatch_q;
        unique case (state_q)
            StIdle: begin
                if (seq_ld) begin
                    target_d   = target;
                    count_d    = '0;
                    mismatch_d = 1'b0;
                    match_d    = 1'b0;
                    state_d    = StCollect;
                end
            end
            StCollect: begin
                // A load in the same cycle as a press restarts the attempt and drops the press.
                if (seq_ld) begin
                    target_d   = target;
                    count_d    = '0;
                    mismatch_d = 1'b0;
                    match_d    = 1'b0;
                end else if (press) begin
                    miss       = mismatch_q | (sw != cur_sym);
                    mismatch_d = miss;
                    count_d    = count_inc;
                    // Verdict is registered on entry so it is valid alongside entry_done.
                    if (count_inc == CNT_W'(SEQ_LEN)) begin
                        match_d = ~miss;
                        state_d = StReport;
                    end
                end
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            target_q   <= '0;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            match_q    <= match_d;
        end
    end

    assign entry_done  = (state_q == StReport);
    assign busy        = (state_q == StCollect);
    assign seq_match   = match_q;
    assign entry_count = count_q;

endmodule

// File: tb/tb_sequence_entry.sv
// Directed bench for sequence_entry: reset, correct/wrong entries, bounce rejection,
// restart on reload, reload during report, idle presses and reset mid-entry.
module tb_sequence_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b0;
    logic [1:0] sw = 2'd0;
    logic       seq_ld = 1'b0;
    logic [7:0] target = 8'h00;
    logic       entry_done;
    logic       seq_match;
    logic [2:0] entry_count;
    logic       busy;

    int n_asserts = 0;
    int n_fails   = 0;
    int done_cnt  = 0;

    sequence_entry #(
        .SEQ_LEN        (4),
        .SYM_W          (2),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .sw         (sw),
        .seq_ld     (seq_ld),
        .target     (target),
        .entry_done (entry_done),
        .seq_match  (seq_match),
        .entry_count(entry_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (entry_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] t);
        target = t;
        seq_ld = 1'b1;
        wait_cycles(1);
        seq_ld = 1'b0;
        check("load_busy", 32'(busy), 32'd1);
        check("load_count", 32'(entry_count), 32'd0);
    endtask

    // Clean press: 18 edges until the debounced pulse, one more for the count update.
    task automatic press(input logic [1:0] v);
        sw  = v;
        btn = 1'b1;
        wait_cycles(19);
        btn = 1'b0;
        wait_cycles(20);
    endtask

    task automatic final_press(input logic [1:0] v, input logic exp_match, input logic ld_in_report);
        sw  = v;
        btn = 1'b1;
        wait_cycles(18);
        check("pre_final_count", 32'(entry_count), 32'd3);
        check("pre_final_done", 32'(entry_done), 32'd0);
        wait_cycles(1);
        check("done_pulse", 32'(entry_done), 32'd1);
        check("match_at_done", 32'(seq_match), 32'(exp_match));
        check("count_at_done", 32'(entry_count), 32'd4);
        check("busy_at_done", 32'(busy), 32'd0);
        if (ld_in_report) begin
            target = 8'h00;
            seq_ld = 1'b1;
        end
        wait_cycles(1);
        seq_ld = 1'b0;
        check("done_one_cycle", 32'(entry_done), 32'd0);
        check("count_after_done", 32'(entry_count), 32'd4);
        check("busy_after_done", 32'(busy), 32'd0);
        btn = 1'b0;
        wait_cycles(20);
        check("match_held", 32'(seq_match), 32'(exp_match));
    endtask

    initial begin
        // Reset held 3 cycles with the button already high.
        btn = 1'b1;
        wait_cycles(3);
        check("rst_done", 32'(entry_done), 32'd0);
        check("rst_match", 32'(seq_match), 32'd0);
        check("rst_count", 32'(entry_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Release reset with a load; the held button becomes a press only after 2+16 cycles.
        reset  = 1'b0;
        sw     = 2'd0;
        target = 8'b11_10_01_00;
        seq_ld = 1'b1;
        wait_cycles(1);
        seq_ld = 1'b0;
        check("post_rst_busy", 32'(busy), 32'd1);
        wait_cycles(16);
        check("no_early_press17", 32'(entry_count), 32'd0);
        wait_cycles(1);
        check("no_early_press18", 32'(entry_count), 32'd0);
        wait_cycles(1);
        check("first_press_count", 32'(entry_count), 32'd1);
        btn = 1'b0;
        wait_cycles(20);
        check("release_no_press", 32'(entry_count), 32'd1);

        // Correct entry: remaining symbols 1, 2, 3.
        press(2'd1);
        check("correct_count2", 32'(entry_count), 32'd2);
        press(2'd2);
        check("correct_count3", 32'(entry_count), 32'd3);
        final_press(2'd3, 1'b1, 1'b0);
        check("correct_done_cnt", 32'(done_cnt), 32'd1);

        // Wrong symbol in position 2.
        load(8'b11_10_01_00);
        check("reload_clears_match", 32'(seq_match), 32'd0);
        press(2'd0);
        press(2'd1);
        press(2'd3);
        final_press(2'd3, 1'b0, 1'b0);
        check("wrong_done_cnt", 32'(done_cnt), 32'd2);

        // Bounce: high 10, low 5, high 30 -> exactly one press.
        load(8'b11_10_01_00);
        btn = 1'b1;
        wait_cycles(10);
        btn = 1'b0;
        wait_cycles(5);
        check("bounce_rejected", 32'(entry_count), 32'd0);
        btn = 1'b1;
        wait_cycles(30);
        check("bounce_one_press", 32'(entry_count), 32'd1);
        btn = 1'b0;
        wait_cycles(20);
        check("bounce_release", 32'(entry_count), 32'd1);

        // Restart at count 2 with a press landing in the same cycle as the load.
        press(2'd1);
        check("restart_pre_count", 32'(entry_count), 32'd2);
        btn = 1'b1;
        wait_cycles(18);
        target = 8'b00_01_10_11;
        seq_ld = 1'b1;
        wait_cycles(1);
        seq_ld = 1'b0;
        check("restart_count", 32'(entry_count), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        btn = 1'b0;
        wait_cycles(20);
        check("restart_press_dropped", 32'(entry_count), 32'd0);
        press(2'd3);
        press(2'd2);
        press(2'd1);
        // Reload during the report cycle must be ignored.
        final_press(2'd0, 1'b1, 1'b1);
        check("restart_done_cnt", 32'(done_cnt), 32'd3);

        // Presses in IDLE change nothing.
        press(2'd0);
        check("idle_count", 32'(entry_count), 32'd4);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done_cnt", 32'(done_cnt), 32'd3);

        // Reset at count 3 discards the attempt.
        load(8'b11_10_01_00);
        press(2'd0);
        press(2'd1);
        press(2'd2);
        check("mid_count3", 32'(entry_count), 32'd3);
        reset = 1'b1;
        wait_cycles(1);
        check("mid_rst_count", 32'(entry_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_match", 32'(seq_match), 32'd0);
        reset = 1'b0;
        wait_cycles(30);
        check("mid_rst_no_done", 32'(done_cnt), 32'd3);
        check("mid_rst_count_hold", 32'(entry_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
